// File: rtl/add_share_arb.sv
// Round-robin arbiter sharing one 16-bit prefix adder into a 1-entry result reg.
// Optional handshake counter port txn_cnt when ADD_SHARE_ARB_CNT_EN is defined.
module add_share_arb #(
  parameter int NREQ = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*16-1:0]   req_a,
  input  logic [NREQ*16-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [15:0]          rsp_sum,
  output logic [IDW-1:0]       rsp_id
`ifdef ADD_SHARE_ARB_CNT_EN
  ,
  output logic [15:0]          txn_cnt
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] sel;
  logic           found;
  logic           accept;
  logic           hs;
  logic [15:0]    op_a, op_b, sum;

  // Kogge-Stone prefix carry network, carry-in tied to zero
  function automatic logic [15:0] pp_add(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [15:0] x, g, p, gn, pn;
    x = a ^ b;
    g = a & b;
    p = x;
    for (int l = 0; l < 4; l++) begin
      gn = g;
      pn = p;
      for (int i = 0; i < 16; i++) begin
        if (i >= (1 << l)) begin
          gn[i] = g[i] | (p[i] & g[i-(1<<l)]);
          pn[i] = p[i] & p[i-(1<<l)];
        end
      end
      g = gn;
      p = pn;
    end
    return x ^ {g[14:0], 1'b0};
  endfunction

  // Lowest rotated distance from ptr wins; descending k leaves the nearest.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] &&
            ((i == int'(ptr) + k) ||
             (i == int'(ptr) + k - NREQ))) begin
          sel   = IDW'(i);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == IDW'(i)) begin
        op_a = req_a[16*i +: 16];
        op_b = req_b[16*i +: 16];
      end
    end
  end

  assign sum       = pp_add(op_a, op_b);
  assign accept    = (state == EMPTY) || rsp_ready;
  assign req_ready = (found && accept && rst_n)
                   ? (NREQ'(1) << sel) : '0;
  assign hs        = |(req_valid & req_ready);
  assign rsp_valid = (state == FULL);

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (hs) state_nxt = FULL;
      FULL: begin
        if (hs)             state_nxt = FULL;
        else if (rsp_ready) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_sum <= '0;
      rsp_id  <= '0;
      ptr     <= '0;
    end else if (hs) begin
      rsp_sum <= sum;
      rsp_id  <= sel;
      ptr     <= (sel == IDW'(NREQ - 1))
               ? '0 : sel + IDW'(1);
    end
  end

`ifdef ADD_SHARE_ARB_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  txn_cnt <= '0;
    else if (hs) txn_cnt <= txn_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_add_share_arb.sv
// Scoreboard bench for add_share_arb: directed corner cases then random traffic
// against a round-robin reference model.
module tb_add_share_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*16-1:0] req_a;
  logic [NREQ*16-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_sum;
  logic [IDW-1:0]    rsp_id;
`ifdef ADD_SHARE_ARB_CNT_EN
  logic [15:0]       txn_cnt;
`endif

  add_share_arb #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id)
`ifdef ADD_SHARE_ARB_CNT_EN
    ,
    .txn_cnt   (txn_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]    sum;
    logic [IDW-1:0] id;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: full flag, next-priority index, expected results.
  bit m_full;
  int m_ptr;

  always @(negedge clk) begin
    int g;
    bit acc;
    logic [NREQ-1:0] exp_rdy;
    logic [15:0] s;
    if (!rst_n) begin
      chk(rsp_valid == 1'b0, "rst_valid", 32'(rsp_valid), 0);
      chk(req_ready == '0, "rst_ready", 32'(req_ready), 0);
      m_full = 1'b0;
      m_ptr  = 0;
      sbq.delete();
    end else begin
      chk(rsp_valid == m_full, "valid", 32'(rsp_valid), 32'(m_full));
      acc = !m_full || rsp_ready;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % NREQ])
          g = (m_ptr + k) % NREQ;
      end
      exp_rdy = (acc && g >= 0) ? NREQ'(1 << g) : '0;
      chk(req_ready == exp_rdy, "req_ready", 32'(req_ready), 32'(exp_rdy));
      if (acc && g >= 0) begin
        s = req_a[16*g +: 16] + req_b[16*g +: 16];
        sbq.push_back('{sum: s, id: IDW'(g)});
        m_ptr  = (g + 1) % NREQ;
        m_full = 1'b1;
      end else if (rsp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: pops on every consumed result, checks holding while stalled.
  bit          stalled = 1'b0;
  logic [15:0] held_sum;
  logic [IDW-1:0] held_id;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (stalled && rsp_valid) begin
        chk(rsp_sum == held_sum, "hold_sum", 32'(rsp_sum), 32'(held_sum));
        chk(rsp_id == held_id, "hold_id", 32'(rsp_id), 32'(held_id));
      end
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          chk(1'b0, "unexpected_rsp", 32'(rsp_sum), 0);
        end else begin
          e = sbq.pop_front();
          chk(rsp_sum == e.sum, "sum", 32'(rsp_sum), 32'(e.sum));
          chk(rsp_id == e.id, "id", 32'(rsp_id), 32'(e.id));
        end
      end
      stalled  = rsp_valid && !rsp_ready;
      held_sum = rsp_sum;
      held_id  = rsp_id;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a,
                        input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0]    hs;
    logic [IDW-1:0] hi;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    chk(rsp_valid == 1'b0, "reset_valid", 32'(rsp_valid), 0);
    chk(rsp_sum == 16'h0, "reset_sum", 32'(rsp_sum), 0);
    chk(rsp_id == '0, "reset_id", 32'(rsp_id), 0);
    rst_n = 1'b1;

    set_op(0, 16'h1234, 16'h0FED);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    tick();
    chk(rsp_valid == 1'b1, "d1_valid", 32'(rsp_valid), 1);
    chk(rsp_sum == 16'h2221, "d1_sum", 32'(rsp_sum), 32'h2221);
    chk(rsp_id == 2'd0, "d1_id", 32'(rsp_id), 0);

    set_op(2, 16'hFFFF, 16'h0001);
    req_valid = 4'b0100;
    tick();
    chk(rsp_sum == 16'h0000, "wrap1_sum", 32'(rsp_sum), 0);
    chk(rsp_id == 2'd2, "wrap1_id", 32'(rsp_id), 2);
    set_op(2, 16'h8000, 16'h8000);
    chk(req_ready == 4'b0100, "solo_grant", 32'(req_ready), 32'h4);
    tick();
    chk(rsp_sum == 16'h0000, "wrap2_sum", 32'(rsp_sum), 0);
    chk(rsp_id == 2'd2, "wrap2_id", 32'(rsp_id), 2);
    req_valid = '0;
    tick();
    chk(rsp_valid == 1'b0, "drain_empty", 32'(rsp_valid), 0);

    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 16'(i * 16'h111), 16'h0100);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk(rsp_id == IDW'(k % NREQ), "rr_id", 32'(rsp_id), 32'(k % NREQ));
    end

    rsp_ready = 1'b0;
    hs = rsp_sum;
    hi = rsp_id;
    repeat (3) begin
      tick();
      chk(rsp_sum == hs && rsp_id == hi, "stall_hold",
          {rsp_sum, 14'b0, rsp_id}, {hs, 14'b0, hi});
      chk(req_ready == '0, "stall_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    #1;
    chk(req_ready == 4'b0010, "resume_grant", 32'(req_ready), 32'h2);
    tick();
    rsp_ready = 1'b0;
    tick();
    chk(rsp_valid == 1'b1, "pre_rst_full", 32'(rsp_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk(rsp_valid == 1'b0, "async_valid", 32'(rsp_valid), 0);
    chk(rsp_sum == 16'h0, "async_sum", 32'(rsp_sum), 0);
    chk(req_ready == '0, "async_ready", 32'(req_ready), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk(req_ready == 4'b0001, "post_rst_grant", 32'(req_ready), 32'h1);

    for (int c = 0; c < 600; c++) begin
      tick();
      req_valid = NREQ'($urandom);
      req_a     = {$urandom, $urandom};
      req_b     = {$urandom, $urandom};
      rsp_ready = ($urandom_range(0, 9) < 7);
    end

    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    chk(sbq.size() == 0, "sb_drained", 32'(sbq.size()), 0);

`ifdef ADD_SHARE_ARB_CNT_EN
    do_reset();
    chk(txn_cnt == 16'h0, "cnt_reset", 32'(txn_cnt), 0);
    req_valid = 4'b0001;
    repeat (65537) @(posedge clk);
    #1;
    req_valid = '0;
    chk(txn_cnt == 16'h0001, "cnt_wrap", 32'(txn_cnt), 1);
    repeat (2) tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_share_arb.md
ADD_SHARE_ARB -- requirements
Module: add_share_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port req_valid  in  NREQ  per-requester operand valid.
REQ-005 SHALL have port req_ready  out  NREQ  per-requester accept, one-hot or zero.
REQ-006 SHALL have port req_a  in  NREQ*16  operand A, requester i at bits [16i+15:16i].
REQ-007 SHALL have port req_b  in  NREQ*16  operand B, same packing.
REQ-008 SHALL have port rsp_valid  out  1  result valid.
REQ-009 SHALL have port rsp_ready  in  1  result consumer accept.
REQ-010 SHALL have port rsp_sum  out  16  registered sum.
REQ-011 SHALL have port rsp_id  out  clog2(NREQ)  index of requester that produced rsp_sum.

Function
REQ-012 SHALL compute sums with one shared combinational 16-bit parallel-prefix adder, modulo 2^16, no carry-out or carry-in.
REQ-013 SHALL hold a single-entry output register with states EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-014 SHALL define accept = (state EMPTY) or (rsp_ready=1), evaluated combinationally.
REQ-015 SHALL select among asserted req_valid round-robin, highest priority = (last granted index + 1) mod NREQ.
REQ-016 SHALL assert req_ready[i] only for the selected requester and only when accept=1; all zero otherwise.
REQ-017 SHALL, on a cycle with req_valid[i] & req_ready[i], load rsp_sum = req_a_i + req_b_i, rsp_id = i, rsp_valid = 1 at the next edge (latency 1 cycle).
REQ-018 SHALL update the round-robin pointer only on a completed request handshake.
REQ-019 SHALL, when FULL and rsp_ready=1 with no request handshake, go EMPTY next cycle.
REQ-020 SHALL, when FULL, rsp_ready=1 and a request handshake coincide, stay FULL with the new result (back-to-back, one result per cycle).
REQ-021 SHALL hold rsp_sum, rsp_id and rsp_valid stable while FULL and rsp_ready=0; req_ready all zero.
REQ-022 SHALL not depend on req_ready for req_valid; a requester may drop req_valid without handshake, no state change.
REQ-023 SHALL grant a single requester continuously if it alone keeps req_valid asserted.

Reset
REQ-024 SHALL, on rst_n low, immediately force rsp_valid=0, rsp_sum=0, rsp_id=0, state EMPTY, pointer so requester 0 has highest priority.
REQ-025 SHALL discard an in-flight result when reset asserts mid-operation; req_ready all zero while rst_n low.
REQ-026 SHALL resume accepting on the first rising clk edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with macro ADD_SHARE_ARB_CNT_EN defined, add port txn_cnt  out  16  count of completed request handshakes, reset 0, wraps 0xFFFF->0x0000.
REQ-028 SHALL, without ADD_SHARE_ARB_CNT_EN, omit txn_cnt and its register; all other behaviour identical.

Verification
REQ-029 SHALL cover: reset, req_valid[0]=1, a=0x1234, b=0x0FED, rsp_ready=1 -> next cycle rsp_valid=1, rsp_sum=0x2221, rsp_id=0.
REQ-030 SHALL cover: a=0xFFFF, b=0x0001 -> rsp_sum=0x0000; a=0x8000, b=0x8000 -> rsp_sum=0x0000.
REQ-031 SHALL cover: all four req_valid held high, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0 on consecutive cycles.
REQ-032 SHALL cover: rsp_ready=0 for 3 cycles while FULL -> rsp_sum/rsp_id stable, req_ready=0000; then rsp_ready=1 -> next grant same cycle.
REQ-033 SHALL cover: rst_n pulsed low while FULL -> rsp_valid=0 asynchronously; first post-reset grant goes to requester 0.
REQ-034 SHALL cover (CNT_EN): 65537 handshakes -> txn_cnt=0x0001.
